// File: rtl/ram_ctrl_if.sv
// Host-side handshake bundle for ram_ctrl: burst request, write beats, read beats, status.
interface ram_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    // Every channel transfers on a rising edge where its valid and ready are both high;
    // valid may rise without waiting for ready, and payload must hold until the transfer.
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              vfy_err;

    modport master (
        output req_valid, req_we, req_addr, req_len, wr_valid, wr_data, rd_ready,
        input  req_ready, wr_ready, rd_valid, rd_data, busy, vfy_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data, rd_ready,
        output req_ready, wr_ready, rd_valid, rd_data, busy, vfy_err
    );
endinterface

// File: rtl/ram_ctrl.sv
// Burst sequencer in front of a 16x8 single-port RAM with registered strobes and tri-state bus.
// Define RAM_CTRL_VERIFY_EN to read back and compare every written word (sticky vfy_err).
module ram_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    ram_ctrl_if.slave         host,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_oa,
    output logic              ram_wa,
    inout  wire  [DATA_W-1:0] ram_bus,
    output logic [2:0]        dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_W = 3'd1,
        S_WSTB   = 3'd2,
        S_VRFY   = 3'd3,
        S_RSTB   = 3'd4,
        S_RHOLD  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              beat_end;
    logic              cs_d, oa_d, wa_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        beat_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (host.req_valid) begin
                    addr_d  = host.req_addr;
                    cnt_d   = host.req_len;
                    state_d = host.req_we ? S_WAIT_W : S_RSTB;
                end
            end
            S_WAIT_W: if (host.wr_valid) state_d = S_WSTB;
`ifdef RAM_CTRL_VERIFY_EN
            S_WSTB:   state_d = S_VRFY;
`else
            S_WSTB:   beat_end = 1'b1;
`endif
            S_VRFY:   beat_end = 1'b1;
            S_RSTB:   state_d = S_RHOLD;
            S_RHOLD:  if (host.rd_ready) beat_end = 1'b1;
            default:  state_d = S_IDLE;
        endcase
        // Shared end-of-beat decision for both directions; address wraps modulo 2^ADDR_W.
        if (beat_end) begin
            if (cnt_q == '0) begin
                state_d = S_IDLE;
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_q - ADDR_W'(1);
                state_d = (state_q == S_RHOLD) ? S_RSTB : S_WAIT_W;
            end
        end
    end

    // Strobes are decoded from the next state so that they leave a flop in the state's own cycle.
    always_comb begin
        cs_d = 1'b0;
        oa_d = 1'b0;
        wa_d = 1'b0;
        case (state_d)
            S_WSTB:         begin cs_d = 1'b1; wa_d = 1'b1; end
            S_VRFY, S_RSTB: begin cs_d = 1'b1; oa_d = 1'b1; end
            default:        ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            ram_addr  <= '0;
            ram_cs    <= 1'b0;
            ram_oa    <= 1'b0;
            ram_wa    <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            ram_addr <= addr_d;
            ram_cs   <= cs_d;
            ram_oa   <= oa_d;
            ram_wa   <= wa_d;
            if (state_q == S_WAIT_W && host.wr_valid) wdata_q   <= host.wr_data;
            if (state_q == S_RSTB)                    rd_data_q <= ram_bus;
        end
    end

`ifdef RAM_CTRL_VERIFY_EN
    logic vfy_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         vfy_err_q <= 1'b0;
        else if (state_q == S_VRFY && ram_bus != wdata_q) vfy_err_q <= 1'b1;
    end

    assign host.vfy_err = vfy_err_q;
`else
    assign host.vfy_err = 1'b0;
`endif

    assign ram_bus        = ram_wa ? wdata_q : {DATA_W{1'bz}};
    assign host.req_ready = (state_q == S_IDLE) && !rst;
    assign host.wr_ready  = (state_q == S_WAIT_W);
    assign host.rd_valid  = (state_q == S_RHOLD);
    assign host.rd_data   = rd_data_q;
    assign host.busy      = (state_q != S_IDLE);
    assign dbg_state      = state_q;
endmodule
